// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit adder: one CHUNK-bit ripple slice per register stage, carry handed between stages.
// Optional signed-overflow output OVF is enabled by defining ADDER_OVF_EN.
module pipelined_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
`ifdef ADDER_OVF_EN
  output logic             OVF,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("pipelined_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic adv;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage k owns sum chunks 0..k; operand chunks above k ride along in its skew registers.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                   vi;
    logic                   ci;
    logic                   vld;
    logic                   cy;
    logic [CHUNK-1:0]       a;
    logic [CHUNK-1:0]       b;
    logic [CHUNK:0]         add;
    logic [(k+1)*CHUNK-1:0] sum_d;
    logic [(k+1)*CHUNK-1:0] sum;

    if (k == 0) begin : g_head
      assign vi    = in_valid;
      assign ci    = Cin;
      assign a     = X[CHUNK-1:0];
      assign b     = Y[CHUNK-1:0];
      assign sum_d = add[CHUNK-1:0];
    end else begin : g_body
      assign vi    = g_stage[k-1].vld;
      assign ci    = g_stage[k-1].cy;
      assign a     = g_stage[k-1].g_skew.xs[CHUNK-1:0];
      assign b     = g_stage[k-1].g_skew.ys[CHUNK-1:0];
      assign sum_d = {add[CHUNK-1:0], g_stage[k-1].sum};
    end

    assign add = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        cy  <= 1'b0;
        sum <= '0;
      end else if (adv) begin
        vld <= vi;
        // Data only loads for real transactions so bubbles never leak stale operands.
        if (vi) begin
          cy  <= add[CHUNK];
          sum <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned SW = WIDTH - (k + 1) * CHUNK;
      logic [SW-1:0] xs_d;
      logic [SW-1:0] ys_d;
      logic [SW-1:0] xs;
      logic [SW-1:0] ys;

      if (k == 0) begin : g_src_in
        assign xs_d = X[WIDTH-1:CHUNK];
        assign ys_d = Y[WIDTH-1:CHUNK];
      end else begin : g_src_prev
        assign xs_d = g_stage[k-1].g_skew.xs[SW+CHUNK-1:CHUNK];
        assign ys_d = g_stage[k-1].g_skew.ys[SW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          xs <= '0;
          ys <= '0;
        end else if (adv && vi) begin
          xs <= xs_d;
          ys <= ys_d;
        end
      end
    end
  end

  assign S         = g_stage[STAGES-1].sum;
  assign Cout      = g_stage[STAGES-1].cy;
  assign out_valid = g_stage[STAGES-1].vld;

`ifdef ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is a^b^sum at that bit; signed overflow is that XOR carry-out.
  assign ovf_d = g_stage[STAGES-1].add[CHUNK]
               ^ g_stage[STAGES-1].a[CHUNK-1]
               ^ g_stage[STAGES-1].b[CHUNK-1]
               ^ g_stage[STAGES-1].add[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv && g_stage[STAGES-1].vi) begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
- Parametrised, pipelined two-operand adder with carry-in.
- Splits a WIDTH-bit addition into STAGES = WIDTH/CHUNK ripple chunks, one chunk per register stage, with the carry passed between stages.
- Valid/ready handshake on both sides, throughput of one add per cycle.
- Used as the final carry-propagate adder after the Dadda reduction tree, and as a general-purpose adder elsewhere in the multiplier datapath.

Parameters:
WIDTH, 32, operand and sum width in bits; must be an integer multiple of CHUNK (elaboration error otherwise).
CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK, range 1..WIDTH.

Ports:
clk  input  1  clock, all registers update on rising edge
rst_n  input  1  asynchronous active-low reset
X  input  WIDTH  operand A, unsigned (or two's complement when ADDER_OVF_EN is defined)
Y  input  WIDTH  operand B
Cin  input  1  carry-in to bit 0
in_valid  input  1  X/Y/Cin valid this cycle
in_ready  output  1  block accepts the input this cycle
S  output  WIDTH  sum, bits [WIDTH-1:0] of X+Y+Cin
Cout  output  1  carry out of bit WIDTH-1
out_valid  output  1  S/Cout hold a completed result
out_ready  input  1  downstream accepts the result this cycle

Behaviour:
- Reset, asynchronous on rst_n=0: every valid bit, data register and skew register goes to 0. This gives S=0, Cout=0, out_valid=0, and OVF=0 when the optional feature is present. in_ready follows the advance equation below.
- Advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - No skid buffer.
  - The whole pipeline shifts together when adv=1 and holds every register when adv=0.
- Input transfer: in_valid & in_ready. A cycle with adv=1 and in_valid=0 inserts a bubble (stage valid = 0).
- Stage k, k = 0..STAGES-1:
  - On adv, stage k computes {c_k, s_k} = X[k*CHUNK +: CHUNK] + Y[k*CHUNK +: CHUNK] + c_(k-1), with c_(-1) = Cin.
  - s_k and c_k are registered.
  - Upper operand chunks not yet consumed travel forward in skew registers.
  - Already-computed lower sum chunks travel forward in deskew registers, so all chunks of a transaction leave together.
- Latency: exactly STAGES adv-cycles from input transfer to out_valid=1 with the result. STAGES=1 degenerates to a single registered adder (latency 1).
- Outputs are driven directly from final-stage registers; no combinational path from X/Y to S/Cout.
- Output transfer: out_valid & out_ready. While out_valid=1 and out_ready=0, S/Cout/out_valid stay stable and in_ready=0.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains one result per cycle.
- Arithmetic is modulo 2^WIDTH; Cout is the true carry. Full {Cout,S} = X+Y+Cin for all operands, including all-ones + all-ones + 1 = {1, all-ones}.
- Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
- Values on X/Y/Cin while in_valid=0 must not affect any later output.

Optional Feature:
Macro ADDER_OVF_EN.
- Defined: adds output port OVF (1 bit), registered alongside S.
  - OVF = carry into bit WIDTH-1 XOR Cout, i.e. two's-complement signed overflow.
  - Reset value 0; held stable under stall exactly like S.
- Not defined: no OVF port; behaviour otherwise identical.

Test Plan (WIDTH=32, CHUNK=8, latency 4):
1. Hold rst_n=0 with random X/Y/in_valid -> S=0, Cout=0, out_valid=0 throughout. After release with in_valid=0, out_valid stays 0.
2. Single op X=0xFFFFFFFF, Y=0x00000001, Cin=0, out_ready=1 -> out_valid=1 exactly 4 cycles after transfer with S=0x00000000, Cout=1; carry ripples through all four stages.
3. Back-to-back stream, in_valid=1 for 100 cycles with random X/Y/Cin, out_ready=1 -> 100 results, one per cycle, in order, each matching the reference {Cout,S}=X+Y+Cin. in_ready is constant 1.
4. Stall: issue X=0x12345678, Y=0x0FEDCBA8, Cin=1, then 3 more ops; drop out_ready for 5 cycles once out_valid=1 -> S=0x22222221, Cout=0 held stable, in_ready=0 during stall. After release the remaining 3 results arrive consecutively with no loss or duplication.
5. Reset mid-operation: 3 ops in flight, pulse rst_n low for 1 cycle (asynchronous, mid-cycle) -> out_valid drops immediately, and none of the 3 results ever appear.
6. With ADDER_OVF_EN: X=0x7FFFFFFF, Y=0x00000001, Cin=0 -> S=0x80000000, Cout=0, OVF=1. Then X=0xFFFFFFFF, Y=0x00000001 -> S=0, Cout=1, OVF=0.
